// File: rtl/gcm_aes_core_if.sv
// gcm_aes_core_if: request/data bundle between a GCM client and gcm_aes_core
// Parameter: BYPASS_W - sideband width.
// master: client side (drives i_*, samples o_*); slave: core side.
interface gcm_aes_core_if #(
   parameter int BYPASS_W = 289
);
   logic                i_new_instance;
   logic [127:0]        i_cipher_key;
   logic [95:0]         i_iv;
   logic [3:0]          i_id;
   logic [127:0]        i_plain_text;
   logic [127:0]        i_aad;
   logic [63:0]         i_plain_text_size;
   logic [63:0]         i_aad_size;
   logic [BYPASS_W-1:0] i_bypass_text;
   logic [BYPASS_W-1:0] o_bypass_text;
   logic [127:0]        o_cipher_text;
   logic [127:0]        o_tag;
   logic                o_tag_ready;
   logic                o_cp_ready;
   modport master (
      output i_new_instance, i_cipher_key, i_iv, i_id, i_plain_text, i_aad,
             i_plain_text_size, i_aad_size, i_bypass_text,
      input  o_bypass_text, o_cipher_text, o_tag, o_tag_ready, o_cp_ready
   );
   modport slave (
      input  i_new_instance, i_cipher_key, i_iv, i_id, i_plain_text, i_aad,
             i_plain_text_size, i_aad_size, i_bypass_text,
      output o_bypass_text, o_cipher_text, o_tag, o_tag_ready, o_cp_ready
   );
endinterface

// File: rtl/gcm_aes_core.sv
// gcm_aes_core: single-block AES-128-GCM encryption and tag engine
// Ports: clk, rst (synchronous, active high);
//   bus (gcm_aes_core_if.slave): level request, key/iv/id, plaintext (byte-reversed),
//   AAD, bit sizes, sideband in; ciphertext, tag, ready levels, sideband out.
// Build option GCM_BYPASS_EN: sideband latch present; otherwise o_bypass_text is 0.
module gcm_aes_core #(
   parameter int BYPASS_W = 289
) (
   input logic           clk,
   input logic           rst,
   gcm_aes_core_if.slave bus
);
   localparam logic [2:0] IDLE = 3'd0, AES_H = 3'd1, AES_J0 = 3'd2, AES_CTR = 3'd3,
                          GH_A = 3'd4, GH_C = 3'd5, GH_LEN = 3'd6, DONE = 3'd7;
   localparam logic [79:0] RCON = 80'h01020408102040801b36;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, t;
      r = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         r = b[i] ? r ^ t : r;
         t = xt(t);
      end
      return r;
   endfunction
   // S-box from the field inverse (a^254) followed by the AES affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252, v;
      a2   = gm(a, a);
      a3   = gm(a2, a);
      a6   = gm(a3, a3);
      a12  = gm(a6, a6);
      a15  = gm(a12, a3);
      a30  = gm(a15, a15);
      a60  = gm(a30, a30);
      a120 = gm(a60, a60);
      a240 = gm(a120, a120);
      a252 = gm(a240, a12);
      v    = gm(a252, a2);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction
   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction
   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rkey,
                                              input logic last);
      logic [7:0] b [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[4*c + r] = b[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c];
         a1 = t[4*c + 1];
         a2 = t[4*c + 2];
         a3 = t[4*c + 3];
         o[127 - 32*c -: 32] = last ? {a0, a1, a2, a3} :
            {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o ^ rkey;
   endfunction
   // GCM bit order: vector bit 127 is the x^0 coefficient
   function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] z, v;
      z = '0;
      v = b;
      for (int i = 127; i >= 0; i--) begin
         z = a[i] ? z ^ v : z;
         v = {1'b0, v[127:1]} ^ (v[0] ? {8'he1, 120'd0} : 128'd0);
      end
      return z;
   endfunction
   // keeps the first min(size,128) bits counted from bit 127
   function automatic logic [127:0] len_mask(input logic [63:0] sz);
      logic [7:0] n;
      n = |sz[63:7] ? 8'd128 : {1'b0, sz[6:0]};
      return ~({128{1'b1}} >> n);
   endfunction
   function automatic logic [127:0] byte_rev(input logic [127:0] d);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = d[8*k +: 8];
      return r;
   endfunction
   logic [2:0]   state;
   logic [3:0]   rnd, unused_id_q;
   logic         req_q, cp_rdy, tag_rdy, start, last;
   logic [7:0]   rc;
   logic [95:0]  iv;
   logic [63:0]  pt_size, aad_size;
   logic [127:0] key, rk, s, h, ekj0, p, aad, x, ct, tag;
   logic [127:0] aes_in, rk_next, round_out, gh_in, gh_out;
   always_comb begin
      start     = bus.i_new_instance && !req_q && state == IDLE;
      last      = rnd == 4'd10;
      rc        = 8'(RCON >> (8 * (10 - int'(rnd))));
      aes_in    = state == AES_H ? 128'd0 : {iv, state == AES_J0 ? 32'd1 : 32'd2};
      rk_next   = key_step(rk, rc);
      round_out = aes_round(s, rk_next, last);
      gh_in     = state == GH_A ? aad : state == GH_C ? ct : {aad_size, pt_size};
      gh_out    = gf_mul(x ^ gh_in, h);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rnd     <= '0;
         req_q   <= 1'b0;
         cp_rdy  <= 1'b0;
         tag_rdy <= 1'b0;
         ct      <= '0;
         tag     <= '0;
      end else begin
         req_q <= bus.i_new_instance;
         case (state)
            IDLE: if (start) begin
               key         <= bus.i_cipher_key;
               iv          <= bus.i_iv;
               unused_id_q <= bus.i_id;
               p           <= byte_rev(bus.i_plain_text);
               aad         <= bus.i_aad & len_mask(bus.i_aad_size);
               pt_size     <= bus.i_plain_text_size;
               aad_size    <= bus.i_aad_size;
               x           <= '0;
               rnd         <= '0;
               cp_rdy      <= 1'b0;
               tag_rdy     <= 1'b0;
               ct          <= '0;
               tag         <= '0;
               state       <= AES_H;
            end
            // round 0 is the whitening AddRoundKey; the key schedule restarts per block
            AES_H, AES_J0, AES_CTR: begin
               s   <= rnd == 4'd0 ? aes_in ^ key : round_out;
               rk  <= rnd == 4'd0 ? key : rk_next;
               rnd <= last ? 4'd0 : rnd + 4'd1;
               if (last) begin
                  if (state == AES_H) h <= round_out;
                  if (state == AES_J0) ekj0 <= round_out;
                  if (state == AES_CTR) begin
                     ct     <= (p ^ round_out) & len_mask(pt_size);
                     cp_rdy <= 1'b1;
                  end
                  state <= state + 3'd1;
               end
            end
            GH_A: begin
               if (aad_size != 64'd0) x <= gh_out;
               state <= GH_C;
            end
            GH_C: begin
               if (pt_size != 64'd0) x <= gh_out;
               state <= GH_LEN;
            end
            GH_LEN: begin
               tag     <= gh_out ^ ekj0;
               tag_rdy <= 1'b1;
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.o_cipher_text = ct;
   assign bus.o_tag         = tag;
   assign bus.o_cp_ready    = cp_rdy;
   assign bus.o_tag_ready   = tag_rdy;
`ifdef GCM_BYPASS_EN
   logic [BYPASS_W-1:0] byp_q, byp;
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_q <= '0;
         byp   <= '0;
      end else begin
         if (start) byp_q <= bus.i_bypass_text;
         if (state == AES_CTR && last) byp <= byp_q;
      end
   end
   assign bus.o_bypass_text = byp;
`else
   logic unused_bypass;
   assign unused_bypass     = ^bus.i_bypass_text;
   assign bus.o_bypass_text = '0;
`endif
endmodule

// File: tb/tb_gcm_aes_core.sv
// tb_gcm_aes_core: directed and randomized checks of gcm_aes_core against a byte-level GCM model
module tb_gcm_aes_core;
   localparam int BW = 289;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [7:0] sb [256];
   gcm_aes_core_if #(.BYPASS_W(BW)) bus ();
   gcm_aes_core #(.BYPASS_W(BW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table from the 3 / (1/3) generator walk over GF(2^8)
   task automatic build_sbox();
      logic [7:0] pp, q, t;
      pp = 8'h01;
      q  = 8'h01;
      do begin
         pp = pp ^ (pp << 1) ^ (pp[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         t = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[pp] = t ^ 8'h63;
      end while (pp != 8'h01);
      sb[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
      logic [7:0] w [176];
      logic [7:0] st [16];
      logic [7:0] sh [16];
      logic [7:0] t [4];
      logic [7:0] a [4];
      logic [7:0] rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) w[i] = k[127 - 8*i -: 8];
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = w[i - 4 + j];
         if (i % 16 == 0) begin
            t = '{sb[w[i-3]] ^ rc, sb[w[i-2]], sb[w[i-1]], sb[w[i-4]]};
            rc = xtime(rc);
         end
         for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ t[j];
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ w[i];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) sh[i] = sb[st[(i + 4 * (i % 4)) % 16]];
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = sh[4*c + j];
            for (int j = 0; j < 4; j++)
               st[4*c + j] = (r == 10 ? a[j] : xtime(a[j]) ^ xtime(a[(j+1)%4]) ^ a[(j+1)%4]
                             ^ a[(j+2)%4] ^ a[(j+3)%4]) ^ w[16*r + 4*c + j];
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
      return res;
   endfunction

   // bit-reflect into ordinary polynomials, carry-less multiply, reduce, reflect back
   function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
      logic [254:0] pr;
      logic [127:0] res;
      pr = '0;
      for (int i = 0; i < 128; i++)
         if (a[127 - i])
            for (int j = 0; j < 128; j++) if (b[127 - j]) pr[i + j] = ~pr[i + j];
      for (int d = 254; d >= 128; d--)
         if (pr[d]) begin
            pr[d] = 1'b0;
            pr[d - 121] = ~pr[d - 121];
            pr[d - 126] = ~pr[d - 126];
            pr[d - 127] = ~pr[d - 127];
            pr[d - 128] = ~pr[d - 128];
         end
      for (int i = 0; i < 128; i++) res[127 - i] = pr[i];
      return res;
   endfunction

   function automatic logic [127:0] mask_of(input logic [63:0] sz);
      logic [127:0] m;
      m = '0;
      for (int i = 0; i < 128; i++) if (64'(i) < sz) m[127 - i] = 1'b1;
      return m;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [BW-1:0] rand_byp();
      logic [BW-1:0] v;
      v = '0;
      for (int i = 0; i < BW; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   function automatic logic [63:0] rand_size();
      int sel;
      sel = int'($urandom_range(0, 3));
      return sel == 0 ? 64'd0 : sel == 1 ? 64'($urandom_range(1, 127)) :
             sel == 2 ? 64'd128 : 64'(128 + $urandom_range(1, 5000));
   endfunction

   task automatic drive(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] aad,
                        input logic [95:0] iv, input logic [63:0] psz, input logic [63:0] asz,
                        input logic [BW-1:0] byp);
      bus.i_cipher_key      = k;
      bus.i_iv              = iv;
      bus.i_id              = 4'($urandom_range(0, 15));
      for (int k2 = 0; k2 < 16; k2++) bus.i_plain_text[8*k2 +: 8] = pt[127 - 8*k2 -: 8];
      bus.i_aad             = aad;
      bus.i_plain_text_size = psz;
      bus.i_aad_size        = asz;
      bus.i_bypass_text     = byp;
   endtask

   function automatic logic [BW-1:0] exp_byp(input logic [BW-1:0] byp);
`ifdef GCM_BYPASS_EN
      return byp;
`else
      return byp & '0;
`endif
   endfunction

   task automatic run_inst(input string name, input logic [127:0] k, input logic [127:0] pt,
                           input logic [127:0] aad, input logic [95:0] iv, input logic [63:0] psz,
                           input logic [63:0] asz, input logic [BW-1:0] byp,
                           output logic [127:0] ct_o, output logic [127:0] tag_o);
      logic [127:0] h, ekj0, exp_ct, x, exp_tag, got_ct, got_tag;
      logic [BW-1:0] got_byp;
      int cp_at, tag_at;
      h      = aes_enc(k, 128'd0);
      ekj0   = aes_enc(k, {iv, 32'd1});
      exp_ct = (pt ^ aes_enc(k, {iv, 32'd2})) & mask_of(psz);
      x      = '0;
      if (asz != 0) x = gf_mul(x ^ (aad & mask_of(asz)), h);
      if (psz != 0) x = gf_mul(x ^ exp_ct, h);
      x       = gf_mul(x ^ {asz, psz}, h);
      exp_tag = x ^ ekj0;
      @(negedge clk);
      drive(k, pt, aad, iv, psz, asz, byp);
      bus.i_new_instance = 1'b1;
      @(posedge clk);
      #1;
      check({name, "/clear"}, BW'({bus.o_cp_ready, bus.o_tag_ready, bus.o_cipher_text, bus.o_tag}), '0);
      @(negedge clk);
      bus.i_new_instance = 1'b0;
      drive(rand128(), rand128(), rand128(), rand128()[95:0], rand_size(), rand_size(), rand_byp());
      cp_at   = -1;
      tag_at  = -1;
      got_ct  = 'x;
      got_tag = 'x;
      got_byp = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (cp_at < 0 && bus.o_cp_ready) begin
            cp_at   = n;
            got_ct  = bus.o_cipher_text;
            got_byp = bus.o_bypass_text;
         end
         if (tag_at < 0 && bus.o_tag_ready) begin
            tag_at  = n;
            got_tag = bus.o_tag;
         end
      end
      check({name, "/cp_cycle"}, BW'(cp_at), BW'(33));
      check({name, "/tag_cycle"}, BW'(tag_at), BW'(36));
      check({name, "/ct"}, BW'(got_ct), BW'(exp_ct));
      check({name, "/tag"}, BW'(got_tag), BW'(exp_tag));
      check({name, "/bypass"}, got_byp, exp_byp(byp));
      check({name, "/hold"}, BW'({bus.o_cp_ready, bus.o_tag_ready, bus.o_cipher_text, bus.o_tag}),
            BW'({2'b11, exp_ct, exp_tag}));
      ct_o  = got_ct;
      tag_o = got_tag;
   endtask

   initial begin
      logic [127:0] ct, tg, got_tag;
      logic [BW-1:0] got_byp;
      int cp_at, tag_at;
      build_sbox();
      bus.i_new_instance = 1'b0;
      drive('0, '0, '0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("reset/outs", BW'({bus.o_cp_ready, bus.o_tag_ready, bus.o_cipher_text, bus.o_tag}), '0);
      check("reset/bypass", bus.o_bypass_text, '0);
      @(negedge clk);
      rst = 1'b0;

      run_inst("empty", '0, '0, '0, '0, 64'd0, 64'd0, rand_byp(), ct, tg);
      check("empty/tag_kat", BW'(tg), BW'(128'h58e2fccefa7e3061367f1d57a4e7455a));

      run_inst("zero", '0, '0, '0, '0, 64'd128, 64'd0, rand_byp(), ct, tg);
      check("zero/ct_kat", BW'(ct), BW'(128'h0388dace60b6a392f328c2b971b2fe78));
      check("zero/tag_kat", BW'(tg), BW'(128'hab6e47d42cec13bdf53a67b21257bddf));

      run_inst("partial", '0, '0, '0, '0, 64'd64, 64'd0, rand_byp(), ct, tg);
      check("partial/ct_kat", BW'(ct), BW'(128'h0388dace60b6a392_0000000000000000));

      run_inst("aad_only", '0, rand128(), 128'h3ad77bb40d7a3660a89ecaf32466ef97, '0, 64'd0, 64'd128,
               rand_byp(), ct, tg);
      check("aad_only/ct_zero", BW'(ct), '0);

      // request held 8 cycles, dropped, re-raised at cycle 10 and held past completion
      @(negedge clk);
      drive('0, '0, '0, '0, 64'd0, 64'd0, BW'(24'hF5269A));
      bus.i_new_instance = 1'b1;
      cp_at   = -1;
      tag_at  = -1;
      got_tag = 'x;
      got_byp = 'x;
      for (int n = 0; n <= 50; n++) begin
         @(posedge clk);
         #1;
         if (n == 0) bus.i_bypass_text = BW'(8'h9A);
         if (n == 7) bus.i_new_instance = 1'b0;
         if (n == 9) bus.i_new_instance = 1'b1;
         if (n == 45) bus.i_new_instance = 1'b0;
         if (cp_at < 0 && bus.o_cp_ready) begin
            cp_at   = n;
            got_byp = bus.o_bypass_text;
         end
         if (tag_at < 0 && bus.o_tag_ready) begin
            tag_at  = n;
            got_tag = bus.o_tag;
         end
      end
      check("held/cp_cycle", BW'(cp_at), BW'(33));
      check("held/tag_cycle", BW'(tag_at), BW'(36));
      check("held/bypass", got_byp, exp_byp(BW'(24'hF5269A)));
      check("held/tag_kat", BW'(got_tag), BW'(128'h58e2fccefa7e3061367f1d57a4e7455a));
      check("held/single_instance", BW'({bus.o_cp_ready, bus.o_tag_ready}), BW'(2'b11));

      // reset during the J0 block, then a clean instance
      @(negedge clk);
      drive('0, '0, '0, '0, 64'd0, 64'd0, rand_byp());
      bus.i_new_instance = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_new_instance = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst/outs", BW'({bus.o_cp_ready, bus.o_tag_ready, bus.o_cipher_text, bus.o_tag}), '0);
      check("midrst/bypass", bus.o_bypass_text, '0);
      @(negedge clk);
      rst = 1'b0;
      run_inst("after_rst", '0, '0, '0, '0, 64'd0, 64'd0, rand_byp(), ct, tg);
      check("after_rst/tag_kat", BW'(tg), BW'(128'h58e2fccefa7e3061367f1d57a4e7455a));

      for (int i = 0; i < 6; i++)
         run_inst($sformatf("rand%0d", i), rand128(), rand128(), rand128(), rand128()[95:0],
                  rand_size(), rand_size(), rand_byp(), ct, tg);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
